// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between the instruction-fetch port and the data port.
// Data wins arbitration. A streak limit forces instruction service, and a watchdog aborts stuck accesses.
module memory_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_rdy,
  output logic        err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } stateT;

  stateT         r_state;
  stateT         w_next;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streakNext;
  logic [WW-1:0] r_wait;
  logic [WW-1:0] w_waitNext;
  logic          r_err;
  logic          w_errSet;
  logic          w_dreq;

  assign w_dreq = dREN | dWEN;
  assign err    = r_err;

  // Arbitration always sees the streak value that will be in effect after this cycle.
  function automatic stateT arb(input logic [SW-1:0] streak, input logic ireq, input logic dreq);
    if (ireq && ((streak == STREAK_MAX) || !dreq)) return IACC;
    else if (dreq)                                 return DACC;
    else                                           return IDLE;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_wait   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_streak <= w_streakNext;
      r_wait   <= w_waitNext;
      r_err    <= r_err | w_errSet;
    end
  end

  // A dropped request aborts before ram_rdy is considered, so no hit is produced for it.
  always_comb begin
    w_next       = r_state;
    w_streakNext = r_streak;
    w_waitNext   = '0;
    w_errSet     = 1'b0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    iload        = '0;
    dload        = '0;
    unique case (r_state)
      IDLE: begin
        w_next = arb(r_streak, iREN, w_dreq);
      end
      IACC: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_rdy) begin
            ihit         = 1'b1;
            iload        = ramload;
            w_streakNext = '0;
            w_next       = arb('0, iREN, w_dreq);
          end else if (r_wait == WAIT_LAST) begin
            w_errSet = 1'b1;
            w_next   = IDLE;
          end else begin
            w_waitNext = r_wait + 1'b1;
          end
        end
      end
      DACC: begin
        if (!w_dreq) begin
          w_next = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ram_rdy) begin
            dhit  = 1'b1;
            dload = dWEN ? '0 : ramload;
            if (!iREN)                        w_streakNext = '0;
            else if (r_streak == STREAK_MAX)  w_streakNext = STREAK_MAX;
            else                              w_streakNext = r_streak + 1'b1;
            w_next = arb(w_streakNext, iREN, w_dreq);
          end else if (r_wait == WAIT_LAST) begin
            w_errSet = 1'b1;
            w_next   = IDLE;
          end else begin
            w_waitNext = r_wait + 1'b1;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule
